// File: rtl/pad_in_filter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : pad_in_pkg
// Purpose  : Shared sizing defaults, the stability-counter type and the
//            effective-threshold helper for the pad input filter.
// Revision : 1.0  initial release
// ============================================================================
package pad_in_pkg;

   localparam int N_IO_DEFAULT  = 48;
   localparam int CNT_W_DEFAULT = 8;

   typedef logic [CNT_W_DEFAULT-1:0] pad_cnt_t;

   // A programmed threshold of 0 would mean "never stable"; treat it as 1 so
   // that the filter degenerates into a single-cycle delay instead of locking.
   function automatic pad_cnt_t eff_thresh(input pad_cnt_t thresh);
      return (thresh == '0) ? pad_cnt_t'(1) : thresh;
   endfunction

endpackage : pad_in_pkg
`default_nettype wire

// File: rtl/pad_in_filter_cell.sv
`default_nettype none
// ============================================================================
// Module   : pad_in_filter_cell
// Purpose  : One pad input: 2-flop synchronizer, glitch filter with a
//            consecutive-cycle stability counter, registered edge pulses.
// Ports    : clk_i      SoC clock
//            rst_ni     async reset, active-low
//            io_in_i    raw asynchronous pad value
//            filt_en_i  1 = filter, 0 = bypass
//            teff_i     effective stability threshold (never 0)
//            sync_o     synchronized value
//            filt_o     filtered value
//            rise_o     1-cycle pulse on filt_o 0->1
//            fall_o     1-cycle pulse on filt_o 1->0
// Revision : 1.0  initial release
// ============================================================================
module pad_in_filter_cell #(
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             io_in_i,
   input  logic             filt_en_i,
   input  logic [CNT_W-1:0] teff_i,
   output logic             sync_o,
   output logic             filt_o,
   output logic             rise_o,
   output logic             fall_o
);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             filt_q,  filt_d;
   logic             rise_q,  rise_d;
   logic             fall_q,  fall_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [CNT_W:0]   cnt_inc;

   // One extra bit so cnt+1 cannot wrap before the compare.
   assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);

   always_comb begin
      sync1_d = io_in_i;
      sync2_d = sync1_q;
      filt_d  = filt_q;
      cnt_d   = cnt_q;
      if (!filt_en_i) begin
         filt_d = sync2_q;
         cnt_d  = '0;
      end else if (sync2_q == filt_q) begin
         cnt_d = '0;
      end else if (cnt_inc >= {1'b0, teff_i}) begin
         // ">=" rather than "==" so a threshold lowered mid-count still flips.
         filt_d = ~filt_q;
         cnt_d  = '0;
      end else begin
         cnt_d = cnt_inc[CNT_W-1:0];
      end
      rise_d = filt_d & ~filt_q;
      fall_d = ~filt_d & filt_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         filt_q  <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         filt_q  <= filt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         cnt_q   <= cnt_d;
      end
   end

   assign sync_o = sync2_q;
   assign filt_o = filt_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule : pad_in_filter_cell
`default_nettype wire

// File: rtl/pad_in_filter.sv
`default_nettype none
// ============================================================================
// Module   : pad_in_filter
// Purpose  : Per-pad synchronizer, glitch filter and edge detector for all
//            pad inputs, with optional sticky edge-pending interrupt logic.
// Config   : PAD_IN_EDGE_IRQ_EN  - when defined, adds irq_en_i, pend_clr_i,
//                                  pend_o and irq_o plus the pend flops.
// Ports    : clk_i, rst_ni         clock / async active-low reset
//            io_in_i               raw pad inputs
//            filt_en_i             per-pad filter enable (0 = bypass)
//            filt_thresh_i         shared stability threshold
//            sync_o, filt_o        synchronized / filtered values
//            rise_o, fall_o        1-cycle edge pulses of filt_o
//            irq_en_i, pend_clr_i  edge capture enable / W1C clear
//            pend_o, irq_o         sticky pending flags / OR of them
// Revision : 1.0  initial release
// ============================================================================
module pad_in_filter
   import pad_in_pkg::*;
#(
   parameter int N_IO  = N_IO_DEFAULT,
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [N_IO-1:0]  io_in_i,
   input  logic [N_IO-1:0]  filt_en_i,
   input  logic [CNT_W-1:0] filt_thresh_i,
   output logic [N_IO-1:0]  sync_o,
   output logic [N_IO-1:0]  filt_o,
   output logic [N_IO-1:0]  rise_o,
`ifdef PAD_IN_EDGE_IRQ_EN
   output logic [N_IO-1:0]  fall_o,
   input  logic [N_IO-1:0]  irq_en_i,
   input  logic [N_IO-1:0]  pend_clr_i,
   output logic [N_IO-1:0]  pend_o,
   output logic             irq_o
`else
   output logic [N_IO-1:0]  fall_o
`endif
);

   logic [CNT_W-1:0] teff;

   // The package helper is typed on the default width; other widths use the
   // same rule inline.
   generate
      if (CNT_W == CNT_W_DEFAULT) begin : g_teff_pkg
         assign teff = CNT_W'(eff_thresh(pad_cnt_t'(filt_thresh_i)));
      end else begin : g_teff_generic
         assign teff = (filt_thresh_i == '0) ? CNT_W'(1) : filt_thresh_i;
      end
   endgenerate

   generate
      for (genvar n = 0; n < N_IO; n++) begin : g_pad
         pad_in_filter_cell #(
            .CNT_W (CNT_W)
         ) u_cell (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .io_in_i   (io_in_i[n]),
            .filt_en_i (filt_en_i[n]),
            .teff_i    (teff),
            .sync_o    (sync_o[n]),
            .filt_o    (filt_o[n]),
            .rise_o    (rise_o[n]),
            .fall_o    (fall_o[n])
         );
      end
   endgenerate

`ifdef PAD_IN_EDGE_IRQ_EN
   logic [N_IO-1:0] pend_q, pend_d;
   logic            irq_q,  irq_d;

   // Set term is ORed last so a new edge wins over a simultaneous clear.
   always_comb begin
      pend_d = (pend_q & ~pend_clr_i) | (irq_en_i & (rise_o | fall_o));
      irq_d  = |pend_d;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         irq_q  <= irq_d;
      end
   end

   assign pend_o = pend_q;
   assign irq_o  = irq_q;
`endif

endmodule : pad_in_filter
`default_nettype wire

// File: tb/tb_pad_in_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pad_in_filter
// Purpose  : Directed self-checking bench for pad_in_filter (48 pads, 8-bit
//            threshold). Edge-IRQ checks are built when PAD_IN_EDGE_IRQ_EN
//            is defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_pad_in_filter;

   localparam int N_IO  = 48;
   localparam int CNT_W = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N_IO-1:0]   io_in;
   logic [N_IO-1:0]   filt_en;
   logic [CNT_W-1:0]  thresh;
   logic [N_IO-1:0]   sync_v, filt_v, rise_v, fall_v;
`ifdef PAD_IN_EDGE_IRQ_EN
   logic [N_IO-1:0]   irq_en, pend_clr, pend_v;
   logic              irq_v;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pad_in_filter #(
      .N_IO  (N_IO),
      .CNT_W (CNT_W)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .io_in_i       (io_in),
      .filt_en_i     (filt_en),
      .filt_thresh_i (thresh),
      .sync_o        (sync_v),
      .filt_o        (filt_v),
      .rise_o        (rise_v),
`ifdef PAD_IN_EDGE_IRQ_EN
      .fall_o        (fall_v),
      .irq_en_i      (irq_en),
      .pend_clr_i    (pend_clr),
      .pend_o        (pend_v),
      .irq_o         (irq_v)
`else
      .fall_o        (fall_v)
`endif
   );

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      io_in   = '1;
      filt_en = '0;
      thresh  = '0;
`ifdef PAD_IN_EDGE_IRQ_EN
      irq_en   = '0;
      pend_clr = '0;
`endif
      // 1. reset with all-ones inputs, then release
      tick(2);
      chk("rst_sync", 64'(sync_v), 64'h0);
      chk("rst_filt", 64'(filt_v), 64'h0);
      chk("rst_rise", 64'(rise_v), 64'h0);
      chk("rst_fall", 64'(fall_v), 64'h0);
`ifdef PAD_IN_EDGE_IRQ_EN
      chk("rst_pend", 64'(pend_v), 64'h0);
      chk("rst_irq",  64'(irq_v),  64'h0);
`endif
      rst_n = 1'b1;
      tick();
      chk("rel_sync_e1", 64'(sync_v), 64'h0);
      chk("rel_rise_e1", 64'(rise_v), 64'h0);
      tick();
      chk("rel_sync_e2", 64'(sync_v), 64'hFFFF_FFFF_FFFF);
      chk("rel_filt_e2", 64'(filt_v), 64'h0);
      tick();
      chk("rel_filt_e3", 64'(filt_v), 64'hFFFF_FFFF_FFFF);
      chk("rel_rise_e3", 64'(rise_v), 64'hFFFF_FFFF_FFFF);
      tick();
      chk("rel_rise_e4", 64'(rise_v), 64'h0);
      chk("rel_fall_e4", 64'(fall_v), 64'h0);

      // all pads back to 0 in bypass
      io_in = '0;
      tick(3);
      chk("all_fall", 64'(fall_v), 64'hFFFF_FFFF_FFFF);
      chk("all_filt0", 64'(filt_v), 64'h0);
      tick();
      chk("all_fall_end", 64'(fall_v), 64'h0);

      // 2. bypass latency on pad 5
      io_in[5] = 1'b1;
      tick();
      chk("byp_sync_k", 64'(sync_v[5]), 64'h0);
      tick();
      chk("byp_sync_k1", 64'(sync_v[5]), 64'h1);
      chk("byp_filt_k1", 64'(filt_v[5]), 64'h0);
      tick();
      chk("byp_filt_k2", 64'(filt_v[5]), 64'h1);
      chk("byp_rise_k2", 64'(rise_v), 64'h20);
      tick();
      chk("byp_rise_k3", 64'(rise_v), 64'h0);
      io_in[5] = 1'b0;
      tick(4);

      // 3. glitch reject on pad 7, T=4
      filt_en[7] = 1'b1;
      thresh     = 8'd4;
      io_in[7]   = 1'b1;
      tick(3);
      io_in[7]   = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("glitch_filt", 64'(filt_v[7]), 64'h0);
         chk("glitch_rise", 64'(rise_v[7]), 64'h0);
      end
      io_in[7] = 1'b1;
      tick(2);
      chk("lvl_sync", 64'(sync_v[7]), 64'h1);
      tick(3);
      chk("lvl_filt_3", 64'(filt_v[7]), 64'h0);
      tick();
      chk("lvl_filt_4", 64'(filt_v[7]), 64'h1);
      chk("lvl_rise_4", 64'(rise_v), 64'h80);
      io_in[7] = 1'b0;
      tick(8);
      chk("lvl_back0", 64'(filt_v[7]), 64'h0);

      // 4a. T=0 acts as T=1
      thresh   = 8'd0;
      io_in[7] = 1'b1;
      tick(2);
      chk("t0_filt_2", 64'(filt_v[7]), 64'h0);
      tick();
      chk("t0_filt_3", 64'(filt_v[7]), 64'h1);
      io_in[7] = 1'b0;
      tick(5);

      // 4b. T=255 needs 255 stable cycles
      thresh   = 8'd255;
      io_in[7] = 1'b1;
      tick(256);
      chk("t255_filt_254", 64'(filt_v[7]), 64'h0);
      tick();
      chk("t255_filt_255", 64'(filt_v[7]), 64'h1);
      chk("t255_rise", 64'(rise_v[7]), 64'h1);
      io_in[7] = 1'b0;
      thresh   = 8'd0;
      tick(5);
      chk("t255_back0", 64'(filt_v[7]), 64'h0);

      // 4c. lower T from 10 to 2 with cnt=5
      thresh   = 8'd10;
      io_in[7] = 1'b1;
      tick(7);
      chk("tlow_filt_cnt5", 64'(filt_v[7]), 64'h0);
      thresh = 8'd2;
      tick();
      chk("tlow_filt_flip", 64'(filt_v[7]), 64'h1);
      io_in[7] = 1'b0;
      thresh   = 8'd0;
      tick(5);

      // 6. mode switch on pad 9 at cnt=2
      filt_en[9] = 1'b1;
      thresh     = 8'd4;
      io_in[9]   = 1'b1;
      tick(4);
      chk("mode_filt_cnt2", 64'(filt_v[9]), 64'h0);
      filt_en[9] = 1'b0;
      tick();
      chk("mode_filt_byp", 64'(filt_v[9]), 64'h1);
      chk("mode_rise_byp", 64'(rise_v[9]), 64'h1);
      io_in[9] = 1'b0;
      tick(2);
      chk("mode_sync0", 64'(sync_v[9]), 64'h0);
      chk("mode_filt_hold", 64'(filt_v[9]), 64'h1);
      tick();
      chk("mode_filt0", 64'(filt_v[9]), 64'h0);
      chk("mode_fall", 64'(fall_v[9]), 64'h1);
      tick(2);

`ifdef PAD_IN_EDGE_IRQ_EN
      // 5. edge-pending interrupt on pad 3
      io_in[3] = 1'b1;
      tick(4);
      chk("irq_pre_pend", 64'(pend_v), 64'h0);
      irq_en[3] = 1'b1;
      io_in[3]  = 1'b0;
      tick(3);
      chk("irq_fall", 64'(fall_v[3]), 64'h1);
      chk("irq_pend_pre", 64'(pend_v), 64'h0);
      tick();
      chk("irq_pend_set", 64'(pend_v), 64'h8);
      chk("irq_set", 64'(irq_v), 64'h1);
      io_in[3] = 1'b1;
      tick(3);
      chk("irq_rise", 64'(rise_v[3]), 64'h1);
      pend_clr[3] = 1'b1;
      tick();
      pend_clr[3] = 1'b0;
      chk("irq_setwins_pend", 64'(pend_v), 64'h8);
      chk("irq_setwins_irq", 64'(irq_v), 64'h1);
      pend_clr[3] = 1'b1;
      tick();
      pend_clr[3] = 1'b0;
      chk("irq_clr_pend", 64'(pend_v), 64'h0);
      chk("irq_clr_irq", 64'(irq_v), 64'h0);
`endif

      // reset mid-operation clears everything
      io_in = '1;
      tick(2);
      rst_n = 1'b0;
      #1;
      chk("midrst_sync", 64'(sync_v), 64'h0);
      chk("midrst_filt", 64'(filt_v), 64'h0);
      rst_n = 1'b1;
      tick();
      chk("midrst_rise", 64'(rise_v), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_pad_in_filter
`default_nettype wire
